// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding/hazard unit and its mul/div scoreboard.
package fwd_hazard_unit_pkg;

   localparam int REG_ID_W = 5;

   typedef logic [REG_ID_W-1:0] reg_id_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   // Width of one per-operand forwarding select: 0 = register file, k = stage k-1.
   function automatic int fwd_sel_w(input int num_fwd);
      return $clog2(num_fwd + 1);
   endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Mul/div in-flight tracker: IDLE/BUSY FSM, latency counter and decode hazard compare.
// Register-level tracking is built only when FWD_MD_SCOREBOARD_EN is defined.
module md_scoreboard
   import fwd_hazard_unit_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int REG_W      = 5,
   parameter int MD_LATENCY = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     md_start,
   input  logic [REG_W-1:0]         md_rd_id,
   input  logic [NUM_SRC*REG_W-1:0] id_rs_id,
   input  logic [NUM_SRC-1:0]       id_rs_used,
   input  logic [REG_W-1:0]         id_rd_id,
   input  logic                     id_is_md,
   output md_state_e                md_state,
   output logic                     md_hazard,
   output logic                     md_done,
   output logic                     md_err
);

   localparam int CW = $clog2(MD_LATENCY + 1);

   md_state_e        state_n;
   logic [CW-1:0]    count, count_n;
   logic             err_n;
   logic             busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_state <= IDLE;
         count    <= '0;
         md_err   <= 1'b0;
      end else begin
         md_state <= state_n;
         count    <= count_n;
         md_err   <= err_n;
      end
   end

   always_comb begin
      state_n = md_state;
      count_n = count;
      err_n   = md_err;
      case (md_state)
         IDLE: begin
            if (md_start) begin
               state_n = BUSY;
               count_n = CW'(MD_LATENCY);
            end
         end
         BUSY: begin
            // A second issue while busy is dropped; only the sticky flag records it.
            if (md_start) err_n = 1'b1;
            count_n = count - CW'(1);
            if (count == CW'(1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy    = (md_state == BUSY);
   assign md_done = busy && (count == CW'(1));

`ifdef FWD_MD_SCOREBOARD_EN
   logic [REG_W-1:0] pend_rd;
   logic             pend_valid;
   logic             raw_hit;

   // x0 is never recorded as pending, so a start to x0 only blocks issue of mul/div.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_rd    <= '0;
         pend_valid <= 1'b0;
      end else if (!busy && md_start) begin
         pend_rd    <= md_rd_id;
         pend_valid <= (md_rd_id != '0);
      end else if (md_done) begin
         pend_rd    <= '0;
         pend_valid <= 1'b0;
      end
   end

   always_comb begin
      raw_hit = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (id_rs_used[s] && (id_rs_id[s*REG_W +: REG_W] == pend_rd)) raw_hit = 1'b1;
      end
   end

   assign md_hazard = busy && ((pend_valid && (raw_hit || (id_rd_id == pend_rd))) || id_is_md);
`else
   logic unused_md_inputs;
   assign unused_md_inputs = ^{md_rd_id, id_rs_id, id_rs_used, id_rd_id, id_is_md};
   assign md_hazard = busy;
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects with nearest-stage priority, load-use detection and mul/div stalls.
// Optional macro FWD_MD_SCOREBOARD_EN: per-register mul/div tracking instead of blocking stall.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int NUM_FWD    = 2,
   parameter int REG_W      = 5,
   parameter int MD_LATENCY = 4
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_SRC*REG_W-1:0]                 ex_rs_id,
   input  logic [NUM_SRC*REG_W-1:0]                 id_rs_id,
   input  logic [NUM_SRC-1:0]                       id_rs_used,
   input  logic [REG_W-1:0]                         id_rd_id,
   input  logic                                     id_is_md,
   input  logic                                     ex_is_load,
   input  logic                                     ex_reg_write,
   input  logic [REG_W-1:0]                         ex_rd_id,
   input  logic [NUM_FWD-1:0]                       stage_reg_write,
   input  logic [NUM_FWD*REG_W-1:0]                 stage_rd_id,
   input  logic                                     md_start,
   input  logic [REG_W-1:0]                         md_rd_id,
   output logic [NUM_SRC*fwd_sel_w(NUM_FWD)-1:0]    fwd_sel,
   output logic                                     stall_id,
   output logic                                     bubble_ex,
   output logic                                     md_busy,
   output logic                                     md_done,
   output logic                                     md_err
);

   localparam int SW = fwd_sel_w(NUM_FWD);

   md_state_e md_state;
   logic      md_hazard;
   logic      load_use;

   // Scan furthest to nearest so the nearest matching stage overwrites the result.
   function automatic logic [SW-1:0] pick_stage(input logic [REG_W-1:0] rs,
                                                input logic [NUM_FWD-1:0] wr,
                                                input logic [NUM_FWD*REG_W-1:0] rd);
      logic [SW-1:0] sel;
      sel = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (wr[k] && (rd[k*REG_W +: REG_W] == rs) && (rs != '0)) sel = SW'(k + 1);
      end
      return sel;
   endfunction

   always_comb begin
      fwd_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         fwd_sel[s*SW +: SW] = pick_stage(ex_rs_id[s*REG_W +: REG_W], stage_reg_write, stage_rd_id);
      end
   end

   always_comb begin
      load_use = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (id_rs_used[s] && (id_rs_id[s*REG_W +: REG_W] == ex_rd_id)) load_use = 1'b1;
      end
      load_use = load_use && ex_is_load && ex_reg_write && (ex_rd_id != '0);
   end

   md_scoreboard #(
      .NUM_SRC   (NUM_SRC),
      .REG_W     (REG_W),
      .MD_LATENCY(MD_LATENCY)
   ) u_md_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .md_start  (md_start),
      .md_rd_id  (md_rd_id),
      .id_rs_id  (id_rs_id),
      .id_rs_used(id_rs_used),
      .id_rd_id  (id_rd_id),
      .id_is_md  (id_is_md),
      .md_state  (md_state),
      .md_hazard (md_hazard),
      .md_done   (md_done),
      .md_err    (md_err)
   );

   assign md_busy   = (md_state == BUSY);
   assign stall_id  = load_use || md_hazard;
   assign bubble_ex = load_use || md_hazard;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use, mul/div timing and reset.
module tb_fwd_hazard_unit;

   logic        clk;
   logic        reset;
   logic [9:0]  ex_rs_id;
   logic [9:0]  id_rs_id;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd_id;
   logic        id_is_md;
   logic        ex_is_load;
   logic        ex_reg_write;
   logic [4:0]  ex_rd_id;
   logic [1:0]  stage_reg_write;
   logic [9:0]  stage_rd_id;
   logic        md_start;
   logic [4:0]  md_rd_id;
   logic [3:0]  fwd_sel;
   logic        stall_id;
   logic        bubble_ex;
   logic        md_busy;
   logic        md_done;
   logic        md_err;

   int checks = 0;
   int errors = 0;

`ifdef FWD_MD_SCOREBOARD_EN
   localparam logic UNRELATED_STALL = 1'b0;
`else
   localparam logic UNRELATED_STALL = 1'b1;
`endif

   fwd_hazard_unit #(
      .NUM_SRC   (2),
      .NUM_FWD   (2),
      .REG_W     (5),
      .MD_LATENCY(4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ex_rs_id       (ex_rs_id),
      .id_rs_id       (id_rs_id),
      .id_rs_used     (id_rs_used),
      .id_rd_id       (id_rd_id),
      .id_is_md       (id_is_md),
      .ex_is_load     (ex_is_load),
      .ex_reg_write   (ex_reg_write),
      .ex_rd_id       (ex_rd_id),
      .stage_reg_write(stage_reg_write),
      .stage_rd_id    (stage_rd_id),
      .md_start       (md_start),
      .md_rd_id       (md_rd_id),
      .fwd_sel        (fwd_sel),
      .stall_id       (stall_id),
      .bubble_ex      (bubble_ex),
      .md_busy        (md_busy),
      .md_done        (md_done),
      .md_err         (md_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      ex_rs_id        = '0;
      id_rs_id        = '0;
      id_rs_used      = '0;
      id_rd_id        = '0;
      id_is_md        = 1'b0;
      ex_is_load      = 1'b0;
      ex_reg_write    = 1'b0;
      ex_rd_id        = '0;
      stage_reg_write = '0;
      stage_rd_id     = '0;
      md_start        = 1'b0;
      md_rd_id        = '0;
      cyc();
      cyc();
      chk("rst_busy", md_busy, 1'b0);
      chk("rst_done", md_done, 1'b0);
      chk("rst_err", md_err, 1'b0);
      chk("rst_stall", stall_id, 1'b0);
      chk("rst_fwd", fwd_sel, 4'h0);
      reset = 1'b0;
      cyc();

      // forwarding: both stages write x5, nearest wins
      stage_reg_write = 2'b11;
      stage_rd_id     = {5'd5, 5'd5};
      ex_rs_id        = {5'd0, 5'd5};
      #1 chk("fwd_nearest", fwd_sel, 4'b0001);
      stage_reg_write = 2'b10;
      #1 chk("fwd_far_only", fwd_sel, 4'b0010);
      stage_reg_write = 2'b11;
      ex_rs_id        = {5'd5, 5'd5};
      #1 chk("fwd_both_ops", fwd_sel, 4'b0101);
      stage_rd_id     = {5'd9, 5'd5};
      ex_rs_id        = {5'd9, 5'd7};
      #1 chk("fwd_op1_far_op0_rf", fwd_sel, 4'b1000);
      stage_rd_id     = {5'd0, 5'd0};
      ex_rs_id        = {5'd0, 5'd0};
      #1 chk("fwd_x0", fwd_sel, 4'b0000);
      stage_reg_write = 2'b00;
      stage_rd_id     = {5'd5, 5'd5};
      ex_rs_id        = {5'd5, 5'd5};
      #1 chk("fwd_no_write", fwd_sel, 4'b0000);

      // load-use
      ex_is_load   = 1'b1;
      ex_reg_write = 1'b1;
      ex_rd_id     = 5'd7;
      id_rs_id     = {5'd7, 5'd2};
      id_rs_used   = 2'b11;
      #1 chk("lu_stall", stall_id, 1'b1);
      chk("lu_bubble", bubble_ex, 1'b1);
      id_rs_used = 2'b01;
      #1 chk("lu_unused_op", stall_id, 1'b0);
      ex_rd_id   = 5'd0;
      id_rs_id   = {5'd0, 5'd0};
      id_rs_used = 2'b11;
      #1 chk("lu_x0", stall_id, 1'b0);
      ex_rd_id   = 5'd7;
      id_rs_id   = {5'd7, 5'd2};
      ex_is_load = 1'b0;
      #1 chk("lu_not_load", bubble_ex, 1'b0);
      ex_reg_write = 1'b0;
      ex_rd_id     = 5'd0;

      // mul/div to x3, decode reads x3
      id_rs_id   = {5'd0, 5'd3};
      id_rs_used = 2'b01;
      id_rd_id   = 5'd4;
      md_start   = 1'b1;
      md_rd_id   = 5'd3;
      #1 chk("md_idle_stall", stall_id, 1'b0);
      cyc();
      md_start = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         chk("md_raw_busy", md_busy, 1'b1);
         chk("md_raw_stall", stall_id, 1'b1);
         chk("md_raw_done", md_done, 32'(i == 4));
         cyc();
      end
      chk("md_raw_released", stall_id, 1'b0);
      chk("md_raw_idle", md_busy, 1'b0);
      chk("md_raw_done_low", md_done, 1'b0);

      // back-to-back start, decode reads unrelated x9; extra start while busy
      id_rs_id = {5'd0, 5'd9};
      md_start = 1'b1;
      md_rd_id = 5'd3;
      cyc();
      md_start = 1'b0;
      #1 chk("b2b_busy", md_busy, 1'b1);
      chk("indep_stall", stall_id, UNRELATED_STALL);
      chk("err_before", md_err, 1'b0);
      md_start = 1'b1;
      md_rd_id = 5'd6;
      cyc();
      md_start = 1'b0;
      #1;
      for (int i = 2; i <= 4; i++) begin
         chk("ovr_busy", md_busy, 1'b1);
         chk("ovr_done", md_done, 32'(i == 4));
         chk("ovr_err", md_err, 1'b1);
         cyc();
      end
      chk("ovr_idle", md_busy, 1'b0);
      chk("ovr_err_sticky", md_err, 1'b1);

      // structural: decoded mul/div waits for the one in flight
      id_is_md = 1'b1;
      md_start = 1'b1;
      md_rd_id = 5'd3;
      #1 chk("str_idle", stall_id, 1'b0);
      cyc();
      md_start = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         chk("str_stall", stall_id, 1'b1);
         chk("str_bubble", bubble_ex, 1'b1);
         cyc();
      end
      chk("str_release", stall_id, 1'b0);

      // the waiting mul/div issues, then reset lands in its second busy cycle
      md_start = 1'b1;
      md_rd_id = 5'd3;
      id_is_md = 1'b0;
      id_rs_id = {5'd0, 5'd3};
      cyc();
      md_start = 1'b0;
      #1 chk("str_issue_busy", md_busy, 1'b1);
      cyc();
      chk("pre_rst_stall", stall_id, 1'b1);
      reset = 1'b1;
      #1 chk("rst_mid_busy", md_busy, 1'b0);
      chk("rst_mid_stall", stall_id, 1'b0);
      chk("rst_mid_err", md_err, 1'b0);
      chk("rst_mid_done", md_done, 1'b0);
      cyc();
      reset    = 1'b0;
      md_start = 1'b1;
      md_rd_id = 5'd3;
      cyc();
      md_start = 1'b0;
      #1 chk("post_rst_busy", md_busy, 1'b1);
      chk("post_rst_stall", stall_id, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
